display_arbiter: RTL and testbench

//  Shares the single 4-digit seven-segment display between three value sources
//  (e.g. counter, frequency meter, setpoint). Round-robin arbitration with a

---
 rtl/display_arbiter_pkg.sv | 32 +++
 rtl/display_arbiter_tick_prescaler.sv | 30 +++
 rtl/display_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_display_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/display_arbiter_pkg.sv
// Shared types, sizes and the value clamp for the display arbiter.
package display_pkg;

   localparam int NUM_SRC = 3;
   localparam int VAL_W   = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [VAL_W-1:0] num;
      logic             ovf;
   } clamp_t;

   // Limit a source value to what the four digits can show; flag when clipped.
   function automatic clamp_t clamp_val(input logic [VAL_W-1:0] value,
                                        input logic [VAL_W-1:0] max_val);
      clamp_t res;
      if (value > max_val) begin
         res.num = max_val;
         res.ovf = 1'b1;
      end else begin
         res.num = value;
         res.ovf = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/display_arbiter_tick_prescaler.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable
// so that a timed interval can be measured exactly from the restart edge.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   // Free-running divider, cleared on reset or restart, wrapping at terminal count.
   always_ff @(posedge clk) begin
      if (!rst_n || restart) begin
         cnt_reg <= '0;
      end else if (cnt_reg >= TERM) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign tick = (cnt_reg == TERM);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of one seven-segment display between three sources,
// with a minimum on-screen hold per grant and a blank gap between sources.
module display_arbiter
   import display_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int HOLD_TICKS = 2000,
   parameter int GAP_TICKS  = 100,
   parameter int MAX_VAL    = 999
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] req,
   input  logic [VAL_W-1:0]   data0,
   input  logic [VAL_W-1:0]   data1,
   input  logic [VAL_W-1:0]   data2,
   output logic [NUM_SRC-1:0] ack,
   output logic [NUM_SRC-1:0] grant,
   output logic [VAL_W-1:0]   disp_num,
   output logic               dig_show,
   output logic               ovf
);

   localparam int PTR_W  = $clog2(NUM_SRC);
   localparam int TMAX   = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
   localparam int TCNT_W = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
   localparam logic [VAL_W-1:0]   MAXV     = VAL_W'(MAX_VAL);
   localparam logic [TCNT_W-1:0]  HOLD_LIM = TCNT_W'(HOLD_TICKS);
   localparam logic [TCNT_W-1:0]  GAP_LIM  = TCNT_W'(GAP_TICKS);
   localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

   state_t              state_reg,    state_next;
   logic [PTR_W-1:0]    ptr_reg,      ptr_next;
   logic [TCNT_W-1:0]   tick_cnt_reg, tick_cnt_next;
   logic [NUM_SRC-1:0]  ack_reg,      ack_next;
   logic [NUM_SRC-1:0]  grant_reg,    grant_next;
   logic [VAL_W-1:0]    disp_num_reg, disp_num_next;
   logic                dig_show_reg, dig_show_next;
   logic                ovf_reg,      ovf_next;

   logic                tick;
   logic                restart;
   logic [TCNT_W-1:0]   tick_limit;
   logic                interval_done;
   logic [VAL_W-1:0]    data_arr [NUM_SRC];
   logic [NUM_SRC-1:0]  others_req;
   logic                win_valid;
   logic [PTR_W-1:0]    win_idx;
   int                  cand_idx;
   clamp_t              win_clamp;
   clamp_t              cur_clamp;

   assign data_arr[0] = data0;
   assign data_arr[1] = data1;
   assign data_arr[2] = data2;

   // Requests from sources other than the one currently on screen (pointer = owner).
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_others
         assign others_req[gi] = req[gi] && (ptr_reg != PTR_W'(gi));
      end
   endgenerate

   // Every state entry restarts the timing so hold and gap lengths are exact.
   assign restart = (state_next != state_reg);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   // Interval ends on the clock whose tick reaches the limit, and stays ended.
   assign tick_limit    = (state_reg == GAP) ? GAP_LIM : HOLD_LIM;
   assign interval_done = (tick_cnt_reg >= tick_limit) ||
                          (tick && ((tick_cnt_reg + TCNT_W'(1)) == tick_limit));

   // Round-robin search ptr+1, ptr+2, ptr; iterate backwards so the nearest wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = ptr_reg;
      cand_idx  = 0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand_idx = (int'(ptr_reg) + k) % NUM_SRC;
         if (req[cand_idx]) begin
            win_valid = 1'b1;
            win_idx   = PTR_W'(cand_idx);
         end
      end
   end

   assign win_clamp = clamp_val(data_arr[win_idx], MAXV);
   assign cur_clamp = clamp_val(data_arr[ptr_reg], MAXV);

   // FSM next state, grant bookkeeping and next output values.
   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      ack_next      = '0;
      grant_next    = grant_reg;
      disp_num_next = disp_num_reg;
      dig_show_next = dig_show_reg;
      ovf_next      = ovf_reg;

      case (state_reg)
         IDLE: begin
            if (win_valid) begin
               state_next    = SHOW;
               ptr_next      = win_idx;
               ack_next      = ONE_HOT0 << win_idx;
               grant_next    = ONE_HOT0 << win_idx;
               disp_num_next = win_clamp.num;
               ovf_next      = win_clamp.ovf;
               dig_show_next = 1'b1;
            end
         end

         SHOW: begin
            if (req[ptr_reg]) begin
               disp_num_next = cur_clamp.num;
               ovf_next      = cur_clamp.ovf;
            end
            if (interval_done) begin
               if (|others_req) begin
                  state_next    = GAP;
                  grant_next    = '0;
                  dig_show_next = 1'b0;
                  ovf_next      = 1'b0;
                  disp_num_next = disp_num_reg;
               end else if (!req[ptr_reg]) begin
                  state_next    = IDLE;
                  grant_next    = '0;
                  dig_show_next = 1'b0;
                  ovf_next      = 1'b0;
                  disp_num_next = disp_num_reg;
               end
            end
         end

         GAP: begin
            if (interval_done) begin
               if (win_valid) begin
                  state_next    = SHOW;
                  ptr_next      = win_idx;
                  ack_next      = ONE_HOT0 << win_idx;
                  grant_next    = ONE_HOT0 << win_idx;
                  disp_num_next = win_clamp.num;
                  ovf_next      = win_clamp.ovf;
                  dig_show_next = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next    = IDLE;
            grant_next    = '0;
            dig_show_next = 1'b0;
            ovf_next      = 1'b0;
         end
      endcase
   end

   // Tick counter saturates at the current interval limit and clears on state entry.
   always_comb begin
      tick_cnt_next = tick_cnt_reg;
      if (tick && (tick_cnt_reg < tick_limit)) begin
         tick_cnt_next = tick_cnt_reg + TCNT_W'(1);
      end
      if (restart) begin
         tick_cnt_next = '0;
      end
   end

   // State, pointer, tick counter and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= PTR_W'(NUM_SRC - 1);
         tick_cnt_reg <= '0;
         ack_reg      <= '0;
         grant_reg    <= '0;
         disp_num_reg <= '0;
         dig_show_reg <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         tick_cnt_reg <= tick_cnt_next;
         ack_reg      <= ack_next;
         grant_reg    <= grant_next;
         disp_num_reg <= disp_num_next;
         dig_show_reg <= dig_show_next;
         ovf_reg      <= ovf_next;
      end
   end

   assign ack      = ack_reg;
   assign grant    = grant_reg;
   assign disp_num = disp_num_reg;
   assign dig_show = dig_show_reg;
   assign ovf      = ovf_reg;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with short timing parameters.
module tb_display_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic [9:0] data0, data1, data2;
   logic [2:0] ack, grant;
   logic [9:0] disp_num;
   logic       dig_show, ovf;

   int compared   = 0;
   int mismatched = 0;

   display_arbiter #(
      .TICK_DIV   (4),
      .HOLD_TICKS (3),
      .GAP_TICKS  (2),
      .MAX_VAL    (999)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .data0    (data0),
      .data1    (data1),
      .data2    (data2),
      .ack      (ack),
      .grant    (grant),
      .disp_num (disp_num),
      .dig_show (dig_show),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] e_ack, input logic [2:0] e_grant,
                          input logic [9:0] e_num, input logic e_show, input logic e_ovf);
      chk({tag, ".ack"},      ack,      e_ack);
      chk({tag, ".grant"},    grant,    e_grant);
      chk({tag, ".disp_num"}, disp_num, e_num);
      chk({tag, ".dig_show"}, dig_show, e_show);
      chk({tag, ".ovf"},      ovf,      e_ovf);
      $display("step %-12s t=%0t req=%b ack=%b grant=%b disp=%0d show=%b ovf=%b",
               tag, $time, req, ack, grant, disp_num, dig_show, ovf);
   endtask

   initial begin
      // 1: reset with all requests asserted
      rst_n = 1'b0; req = 3'b111; data0 = 10'd5; data1 = 10'd6; data2 = 10'd7;
      step(3);
      chk_all("reset", 3'b000, 3'b000, 10'd0, 1'b0, 1'b0);

      // 2: single source, request dropped mid-hold freezes value
      rst_n = 1'b1; req = 3'b001; data0 = 10'd123;
      step(1);
      chk_all("t2_grant", 3'b001, 3'b001, 10'd123, 1'b1, 1'b0);
      step(1);
      chk_all("t2_ackoff", 3'b000, 3'b001, 10'd123, 1'b1, 1'b0);
      step(2);
      req = 3'b000; data0 = 10'd321;
      step(8);
      chk_all("t2_frozen", 3'b000, 3'b001, 10'd123, 1'b1, 1'b0);
      step(1);
      chk_all("t2_idle", 3'b000, 3'b000, 10'd123, 1'b0, 1'b0);

      // 3: two requesters, hold then gap then the other source
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1; req = 3'b101; data0 = 10'd100; data2 = 10'd200;
      step(1);
      chk_all("t3_grant0", 3'b001, 3'b001, 10'd100, 1'b1, 1'b0);
      step(11);
      chk_all("t3_holdend", 3'b000, 3'b001, 10'd100, 1'b1, 1'b0);
      step(1);
      chk_all("t3_gap1", 3'b000, 3'b000, 10'd100, 1'b0, 1'b0);
      step(7);
      chk_all("t3_gap8", 3'b000, 3'b000, 10'd100, 1'b0, 1'b0);
      step(1);
      chk_all("t3_grant2", 3'b100, 3'b100, 10'd200, 1'b1, 1'b0);

      // 4: clamp boundaries and live update (mid-operation reset first)
      rst_n = 1'b0;
      step(1);
      chk_all("t4_reset", 3'b000, 3'b000, 10'd0, 1'b0, 1'b0);
      rst_n = 1'b1; req = 3'b010; data1 = 10'd1020;
      step(1);
      chk_all("t4_clamp", 3'b010, 3'b010, 10'd999, 1'b1, 1'b1);
      data1 = 10'd456;
      step(1);
      chk_all("t4_live", 3'b000, 3'b010, 10'd456, 1'b1, 1'b0);
      data1 = 10'd999;
      step(1);
      chk_all("t4_eq_max", 3'b000, 3'b010, 10'd999, 1'b1, 1'b0);
      data1 = 10'd1000;
      step(1);
      chk_all("t4_max_p1", 3'b000, 3'b010, 10'd999, 1'b1, 1'b1);

      // 5: all three requesting, full rotation
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1; req = 3'b111; data0 = 10'd11; data1 = 10'd22; data2 = 10'd33;
      step(1);
      chk_all("t5_g0", 3'b001, 3'b001, 10'd11, 1'b1, 1'b0);
      step(12);
      chk_all("t5_gap_a", 3'b000, 3'b000, 10'd11, 1'b0, 1'b0);
      step(8);
      chk_all("t5_g1", 3'b010, 3'b010, 10'd22, 1'b1, 1'b0);
      step(20);
      chk_all("t5_g2", 3'b100, 3'b100, 10'd33, 1'b1, 1'b0);
      step(20);
      chk_all("t5_g0b", 3'b001, 3'b001, 10'd11, 1'b1, 1'b0);

      // 6: reset during SHOW of source 1 restores pointer
      step(20);
      chk_all("t6_g1", 3'b010, 3'b010, 10'd22, 1'b1, 1'b0);
      step(5);
      rst_n = 1'b0;
      step(1);
      chk_all("t6_reset", 3'b000, 3'b000, 10'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1);
      chk_all("t6_g0", 3'b001, 3'b001, 10'd11, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
